// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port data memory between fetch and data ports
// Optional macro MEM_ARB_RR_EN selects round-robin tie-break; default build uses fixed data priority.
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic       grant;
    logic       pick_d;

`ifdef MEM_ARB_RR_EN
    logic       last_grant;

    // On a tie the port opposite the previous winner is served.
    always_comb begin
        pick_d = d_req & (~if_req | ~last_grant);
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    assign if_stall = if_req & ~if_ack;
    assign d_stall  = d_req & ~d_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            grant     <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_we    <= 1'b0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= 32'd0;
            d_rdata   <= 32'd0;
`ifdef MEM_ARB_RR_EN
            last_grant <= 1'b0;
`endif
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (if_req || d_req) begin
                        grant <= pick_d;
                        cnt   <= CNT_LOAD;
                        state <= ST_ACCESS;
`ifdef MEM_ARB_RR_EN
                        last_grant <= pick_d;
`endif
                        if (pick_d) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_we;
                        end else begin
                            mem_addr  <= if_addr;
                            mem_wdata <= 32'd0;
                            mem_we    <= 1'b0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        // mem_we doubles as the "this is a store" flag, so stores leave rdata alone.
                        if (!mem_we) begin
                            if (grant) begin
                                d_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        if (grant) begin
                            d_ack <= 1'b1;
                        end else begin
                            if_ack <= 1'b1;
                        end
                        mem_we <= 1'b0;
                        state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int LAT = 3;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.MEM_LAT(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_ack     (d_ack),
        .d_stall   (d_stall),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory environment: contents restored while reset is low.
    logic [31:0] mem [0:255];
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[4]   <= 32'h2402_000A;
            mem[8]   <= 32'h3333_4444;
            mem[64]  <= 32'h0000_0000;
            mem[128] <= 32'h1111_2222;
        end else if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every ack and checks per-cycle invariants.
    initial begin
        exp_t e;
        int   we_run;
        we_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                we_run = 0;
            end else begin
                chk("if_stall", 32'(if_req & ~if_ack), 32'(if_stall));
                chk("d_stall", 32'(d_req & ~d_ack), 32'(d_stall));
                chk("dual_ack", 32'(if_ack & d_ack), 32'd0);
                if (if_ack || d_ack) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_ack", {30'd0, d_ack, if_ack}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("ack_port", 32'(d_ack), 32'(e.port));
                        chk("ack_rdata", e.port ? d_rdata : if_rdata, e.rdata);
                    end
                end
                if (mem_we) begin
                    we_run++;
                end else if (we_run != 0) begin
                    chk("mem_we_len", 32'(we_run), 32'(LAT));
                    we_run = 0;
                end
            end
        end
    end

    task automatic wait_ack(input bit port, input string name, output int a);
        bit got;
        got = 1'b0;
        a = 0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (port ? d_ack : if_ack) begin
                got = 1'b1;
                a = cyc;
            end
        end
        chk({name, "_timeout"}, 32'(got), 32'd1);
    endtask

    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input string name);
        int c;
        int a;
        int we_cycles;
        bit got;
        @(posedge clk);
        #1;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        c = cyc;
        sb.push_back('{port, exp_rd});
        @(posedge clk);
        @(negedge clk);
        chk({name, "_mem_addr"}, mem_addr, addr);
        chk({name, "_mem_wdata"}, mem_wdata, port ? wdata : 32'd0);
        we_cycles = 0;
        got = 1'b0;
        a = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (mem_we) we_cycles++;
            if (port ? d_ack : if_ack) begin
                got = 1'b1;
                a = cyc;
            end else begin
                @(negedge clk);
            end
        end
        chk({name, "_timeout"}, 32'(got), 32'd1);
        if (got) chk({name, "_latency"}, 32'(a - c), 32'(LAT + 1));
        chk({name, "_we_cycles"}, 32'(we_cycles), we ? 32'(LAT) : 32'd0);
        @(posedge clk);
        #1;
        if (port) d_req = 1'b0; else if_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int prev;
        int a;
        int a_d;
        int k;
        bit stall_ok;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        exp_if_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_acks", {30'd0, d_ack, if_ack}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Both ports held: grant order depends on tie-break policy.
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
`ifdef MEM_ARB_RR_EN
        sb.push_back('{1'b1, 32'h1111_2222});
        sb.push_back('{1'b0, 32'h3333_4444});
        sb.push_back('{1'b1, 32'h1111_2222});
        sb.push_back('{1'b0, 32'h3333_4444});
`else
        repeat (4) sb.push_back('{1'b1, 32'h1111_2222});
        sb.push_back('{1'b0, 32'h3333_4444});
`endif
        n = 0; prev = 0; k = 0; stall_ok = 1'b1;
        while (n < 4 && k < 200) begin
            @(negedge clk);
            k++;
            if (!if_stall) stall_ok = 1'b0;
            if (if_ack || d_ack) begin
                n++;
                if (n > 1) chk("tie_spacing", 32'(cyc - prev), 32'(LAT + 2));
                prev = cyc;
            end
        end
        chk("tie_4acks", 32'(n), 32'd4);
        @(posedge clk);
        #1;
`ifdef MEM_ARB_RR_EN
        if_req = 1'b0;
        d_req = 1'b0;
`else
        chk("tie_if_stall_held", 32'(stall_ok), 32'd1);
        d_req = 1'b0;
        wait_ack(1'b0, "tie_fetch", a);
        @(posedge clk);
        #1 if_req = 1'b0;
`endif
        exp_if_rdata = 32'h3333_4444;
        exp_d_rdata = 32'h1111_2222;

        do_txn(1'b0, 1'b0, 32'h10, 32'd0, 32'h2402_000A, "fetch");
        exp_if_rdata = 32'h2402_000A;

        do_txn(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, exp_d_rdata, "store");
        chk("store_keeps_d_rdata", d_rdata, 32'h1111_2222);
        do_txn(1'b1, 1'b0, 32'h100, 32'd0, 32'hDEAD_BEEF, "load");
        exp_d_rdata = 32'hDEAD_BEEF;

        // Fetch rises in the second ACCESS cycle of a data load.
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        sb.push_back('{1'b1, 32'h1111_2222});
        @(posedge clk);
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 32'h20;
        sb.push_back('{1'b0, 32'h3333_4444});
        wait_ack(1'b1, "busy_d", a_d);
        @(posedge clk);
        #1 d_req = 1'b0;
        wait_ack(1'b0, "busy_if", a);
        chk("busy_if_delay", 32'(a - a_d), 32'(LAT + 2));
        @(posedge clk);
        #1 if_req = 1'b0;

        // Reset during the second ACCESS cycle of a store.
        @(posedge clk);
        #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_wdata = 32'h55AA_55AA;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_we_before", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        d_req = 1'b0; d_we = 1'b0;
        #1;
        chk("rstmid_mem_we", 32'(mem_we), 32'd0);
        chk("rstmid_mem_addr", mem_addr, 32'd0);
        chk("rstmid_mem_wdata", mem_wdata, 32'd0);
        chk("rstmid_acks", {30'd0, d_ack, if_ack}, 32'd0);
        chk("rstmid_if_rdata", if_rdata, 32'd0);
        chk("rstmid_d_rdata", d_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        exp_if_rdata = 32'd0;
        exp_d_rdata = 32'd0;
        repeat (LAT + 3) @(negedge clk);
        chk("rstmid_no_ack_d_rdata", d_rdata, exp_d_rdata);
        do_txn(1'b0, 1'b0, 32'h10, 32'd0, 32'h2402_000A, "post_rst_fetch");
        chk("post_rst_d_rdata", d_rdata, exp_d_rdata);

        repeat (5) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
